// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the TX scheduler, its source FIFO and the UART transmitter.
interface uart_tx_sched_if #(
  parameter int SIZE_DATA = 8
);
  logic                 i_en;
  logic                 i_fifo_empty;
  logic                 o_fifo_rd_en;
  logic [SIZE_DATA-1:0] i_fifo_data;
  logic                 o_tx_start;
  logic [SIZE_DATA-1:0] o_tx_data;
  logic                 i_tx_busy;
  logic                 i_tx_done;
  logic                 o_active;
  logic [15:0]          o_byte_cnt;

  modport master (
    input  i_en, i_fifo_empty, i_fifo_data, i_tx_busy, i_tx_done,
    output o_fifo_rd_en, o_tx_start, o_tx_data, o_active, o_byte_cnt
  );

  modport slave (
    output i_en, i_fifo_empty, i_fifo_data, i_tx_busy, i_tx_done,
    input  o_fifo_rd_en, o_tx_start, o_tx_data, o_active, o_byte_cnt
  );
endinterface

// File: rtl/uart_tx_sched.sv
// Pops one byte at a time from a TX FIFO, hands it to a UART transmitter and
// enforces an idle gap after each completed frame. All outputs are registered.
module uart_tx_sched #(
  parameter int SIZE_DATA  = 8,
  parameter int GAP_CYCLES = 2
) (
  input logic             i_clk,
  input logic             i_rst_n,
  uart_tx_sched_if.master bus
);
  typedef enum logic [2:0] {IDLE, POP, FETCH, START, WAIT, GAP} state_t;

  localparam logic [7:0] GAP_LAST = 8'((GAP_CYCLES == 0) ? 0 : GAP_CYCLES - 1);

  state_t               state;
  logic [7:0]           gap_cnt;
  logic [15:0]          byte_cnt;
  logic [SIZE_DATA-1:0] tx_data;

  assign bus.o_byte_cnt = byte_cnt;
  assign bus.o_tx_data  = tx_data;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state            <= IDLE;
      gap_cnt          <= '0;
      byte_cnt         <= '0;
      tx_data          <= '0;
      bus.o_fifo_rd_en <= 1'b0;
      bus.o_tx_start   <= 1'b0;
      bus.o_active     <= 1'b0;
    end else begin
      bus.o_fifo_rd_en <= 1'b0;
      bus.o_tx_start   <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.i_en && !bus.i_fifo_empty) begin
            state            <= POP;
            bus.o_fifo_rd_en <= 1'b1;
            bus.o_active     <= 1'b1;
          end
        end
        POP: state <= FETCH;
        FETCH: begin
          tx_data        <= bus.i_fifo_data;
          // Start pulse is registered: busy sampled here decides the pulse in the next cycle.
          bus.o_tx_start <= !bus.i_tx_busy;
          state          <= START;
        end
        START: begin
          if (bus.o_tx_start) state <= WAIT;
          else                bus.o_tx_start <= !bus.i_tx_busy;
        end
        WAIT: begin
          if (bus.i_tx_done) begin
            byte_cnt <= byte_cnt + 16'd1;
            gap_cnt  <= '0;
            if (GAP_CYCLES == 0) begin
              state        <= IDLE;
              bus.o_active <= 1'b0;
            end else begin
              state <= GAP;
            end
          end
        end
        GAP: begin
          if (gap_cnt == GAP_LAST) begin
            state        <= IDLE;
            bus.o_active <= 1'b0;
          end else begin
            gap_cnt <= gap_cnt + 8'd1;
          end
        end
        default: begin
          state        <= IDLE;
          bus.o_active <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench: FIFO and transmitter models drive the DUT; a timestamp-based
// model predicts every output each cycle, with literal checks pinning key latencies.
module tb_uart_tx_sched;
  localparam int SD    = 8;
  localparam int G     = 2;
  localparam int TXLAT = 10;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  uart_tx_sched_if #(.SIZE_DATA(SD)) bus();
  uart_tx_sched #(.SIZE_DATA(SD), .GAP_CYCLES(G)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .bus(bus)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  // environment state
  logic [SD-1:0] q[$];
  logic [SD-1:0] starts[$];
  int            start_cycs[$];
  int            rd_cnt = 0, rd_cyc = 0, done_cyc = 0, idle_cyc = 0;
  int            tx_left = 0, stall = 0;
  logic          tx_pend = 0, inj_done = 0, done_on_start = 0, prev_act = 0;

  // sampled inputs of the previous cycle
  logic          rst_p, en_p, empty_p, busy_p, done_p;
  logic [SD-1:0] data_p;

  // model state
  logic          armed = 0, m_frame = 0, m_started = 0;
  int            m_since = 0, m_start_cyc = 0, m_gap_end = 0;
  logic          m_rd = 0, m_start = 0, m_act = 0;
  logic [SD-1:0] m_data = '0;
  logic [15:0]   m_cnt = '0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      if (failures <= 40)
        $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Expected outputs for the current cycle, from what was sampled at the edge.
  task automatic model_step();
    if (!rst_p) begin
      m_frame = 0; m_started = 0; m_gap_end = 0;
      m_rd = 0; m_start = 0; m_act = 0; m_data = '0; m_cnt = '0;
    end else begin
      m_rd    = !m_act && en_p && !empty_p;
      m_start = 0;
      if (m_rd) begin
        m_frame = 1; m_since = 0; m_started = 0;
      end else if (m_frame) begin
        m_since++;
        if (m_since == 2) m_data = data_p;
        if (m_since >= 2 && !m_started) begin
          if (!busy_p) begin m_start = 1; m_started = 1; m_start_cyc = cyc; end
        end else if (m_started && (cyc - 1 > m_start_cyc) && done_p) begin
          m_cnt     = m_cnt + 16'd1;
          m_frame   = 0;
          m_gap_end = cyc + G;
        end
      end
      m_act = m_frame || (cyc < m_gap_end);
    end
  endtask

  task automatic env_step();
    logic d;
    if (bus.o_fifo_rd_en) begin
      rd_cnt++; rd_cyc = cyc;
      if (q.size() > 0) bus.i_fifo_data = q.pop_front();
    end
    bus.i_fifo_empty = (q.size() == 0);
    d = 0;
    if (bus.o_tx_start) begin
      starts.push_back(bus.o_tx_data); start_cycs.push_back(cyc);
      tx_pend = 1; tx_left = TXLAT;
      if (done_on_start) d = 1;
    end else if (tx_pend) begin
      tx_left--;
      if (tx_left == 0) begin d = 1; tx_pend = 0; done_cyc = cyc; end
    end
    if (inj_done) begin d = 1; inj_done = 0; end
    bus.i_tx_done = d;
    bus.i_tx_busy = tx_pend || (stall > 0);
    if (stall > 0) stall--;
    if (prev_act && !bus.o_active) idle_cyc = cyc;
    prev_act = bus.o_active;
  endtask

  always @(posedge clk) begin
    rst_p = rst_n; en_p = bus.i_en; empty_p = bus.i_fifo_empty;
    data_p = bus.i_fifo_data; busy_p = bus.i_tx_busy; done_p = bus.i_tx_done;
    cyc++;
    #1;
    model_step();
    if (!rst_p) armed = 1;
    if (armed) begin
      chk("rd_en",    32'(bus.o_fifo_rd_en), 32'(m_rd));
      chk("tx_start", 32'(bus.o_tx_start),   32'(m_start));
      chk("tx_data",  32'(bus.o_tx_data),    32'(m_data));
      chk("active",   32'(bus.o_active),     32'(m_act));
      chk("byte_cnt", 32'(bus.o_byte_cnt),   32'(m_cnt));
    end
    env_step();
  end

  task automatic wait_idle(input int maxc, input string nm);
    int n = 0;
    do begin @(negedge clk); n++; end
    while (!(bus.i_fifo_empty && !bus.o_active && !tx_pend) && n < maxc);
    chk({nm, "_idle_timeout"}, 32'(n < maxc), 32'd1);
  endtask

  task automatic wait_starts(input int target, input int maxc, input string nm);
    int n = 0;
    while (starts.size() < target && n < maxc) begin @(negedge clk); n++; end
    chk({nm, "_start_timeout"}, 32'(starts.size() >= target), 32'd1);
  endtask

  task automatic push(input logic [SD-1:0] b);
    q.push_back(b);
    bus.i_fifo_empty = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int base_s, base_rd, rel, n;
    bus.i_en = 0; bus.i_fifo_empty = 1; bus.i_fifo_data = '0;
    bus.i_tx_busy = 0; bus.i_tx_done = 0;

    // reset held with enable and data present
    push(8'hA5); bus.i_en = 1;
    repeat (2) @(negedge clk);
    chk("rst_rd_en",  32'(bus.o_fifo_rd_en), 32'd0);
    chk("rst_active", 32'(bus.o_active),     32'd0);
    chk("rst_cnt",    32'(bus.o_byte_cnt),   32'd0);
    chk("rst_data",   32'(bus.o_tx_data),    32'd0);
    chk("rst_fifo_untouched", 32'(q.size()), 32'd1);
    rst_n = 1; rel = cyc;

    // single byte
    wait_idle(100, "single");
    chk("single_rd_lat",    32'(rd_cyc - rel),        32'd1);
    chk("single_start_lat", 32'(start_cycs[0] - rel), 32'd3);
    chk("single_data",      32'(starts[0]),           32'hA5);
    chk("single_cnt",       32'(bus.o_byte_cnt),      32'd1);
    chk("single_gap",       32'(idle_cyc - done_cyc), 32'(G + 1));

    // burst 0..15
    base_s = starts.size(); base_rd = rd_cnt;
    for (int i = 0; i < 16; i++) push(SD'(i));
    wait_idle(1000, "burst");
    chk("burst_rd", 32'(rd_cnt - base_rd), 32'd16);
    chk("burst_n",  32'(starts.size() - base_s), 32'd16);
    for (int i = 0; i < 16; i++) chk("burst_order", 32'(starts[base_s + i]), 32'(i));
    chk("burst_spacing", 32'(start_cycs[base_s + 1] - start_cycs[base_s]), 32'(TXLAT + G + 4));
    chk("burst_cnt", 32'(bus.o_byte_cnt), 32'd17);

    // busy stall at START
    push(8'h3C);
    n = 0;
    while (!bus.o_fifo_rd_en && n < 20) begin @(negedge clk); n++; end
    chk("stall_pop_seen", 32'(bus.o_fifo_rd_en), 32'd1);
    stall = 6;
    wait_idle(200, "stall");
    chk("stall_data", 32'(starts[starts.size() - 1]), 32'h3C);
    chk("stall_lat",  32'(start_cycs[start_cycs.size() - 1] - rd_cyc), 32'd8);

    // stray done in IDLE, then done coincident with start
    inj_done = 1;
    repeat (4) @(negedge clk);
    chk("stray_done_cnt", 32'(bus.o_byte_cnt), 32'd18);
    done_on_start = 1;
    push(8'h5A);
    wait_idle(200, "coinc");
    done_on_start = 0;
    chk("coinc_cnt", 32'(bus.o_byte_cnt), 32'd19);

    // enable drop during WAIT of byte 3 of 8
    base_s = starts.size(); base_rd = rd_cnt;
    for (int i = 0; i < 8; i++) push(SD'(8'h40 + i));
    wait_starts(base_s + 4, 400, "endrop");
    bus.i_en = 0;
    repeat (40) @(negedge clk);
    chk("endrop_rd",     32'(rd_cnt - base_rd),   32'd4);
    chk("endrop_cnt",    32'(bus.o_byte_cnt),     32'd23);
    chk("endrop_active", 32'(bus.o_active),       32'd0);
    chk("endrop_left",   32'(q.size()),           32'd4);
    bus.i_en = 1;
    wait_idle(600, "endrop_resume");
    chk("endrop_rd_all", 32'(rd_cnt - base_rd), 32'd8);
    for (int i = 0; i < 8; i++) chk("endrop_order", 32'(starts[base_s + i]), 32'(8'h40 + i));

    // counter wrap via preload
    bus.i_en = 0;
    @(negedge clk);
    force dut.byte_cnt = 16'hFFFE;
    m_cnt = 16'hFFFE;
    @(negedge clk);
    release dut.byte_cnt;
    @(negedge clk);
    chk("wrap_preload", 32'(bus.o_byte_cnt), 32'hFFFE);
    push(8'h11); push(8'h22); bus.i_en = 1;
    n = 0;
    while (bus.o_byte_cnt != 16'hFFFF && n < 200) begin @(negedge clk); n++; end
    chk("wrap_ffff", 32'(bus.o_byte_cnt), 32'hFFFF);
    wait_idle(200, "wrap");
    chk("wrap_zero", 32'(bus.o_byte_cnt), 32'd0);

    // reset asserted in WAIT
    push(8'h77);
    wait_starts(starts.size() + 1, 100, "rstwait");
    @(negedge clk);
    rst_n = 0;
    @(negedge clk);
    chk("rstwait_active", 32'(bus.o_active),     32'd0);
    chk("rstwait_cnt",    32'(bus.o_byte_cnt),   32'd0);
    chk("rstwait_start",  32'(bus.o_tx_start),   32'd0);
    chk("rstwait_rd",     32'(bus.o_fifo_rd_en), 32'd0);
    rst_n = 1;
    repeat (20) @(negedge clk);
    chk("rstwait_idle", 32'(bus.o_active), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
